sm_clk_gen: RTL
===============

Name: sm_clk_gen

Overview:
Programmable clock generator for the single-cycle core's slow clock.
- Divides clkIn by any even ratio 2·(D+1), not only powers of two, with a guaranteed 50% duty cycle.
- Supports run, stop and single-step modes, with an on-chip synchroniser for the asynchronous switch and button inputs.
- Provides a one-cycle enable strobe and a count of generated cycles, for board debug and LED display.

Parameters:
DIV_W  16  width of divide input; half-period = divide+1 clkIn cycles
CNT_W  32  width of cycleCnt output
SYNC_STAGES  2  flops in each input synchroniser chain (minimum 2)

Ports:
clkIn  in  1  single clock; all logic on its rising edge
rst  in  1  synchronous reset, active-high
divide  in  DIV_W  half-period minus one (asynchronous, from switches)
mode  in  2  00 STOP, 01 RUN, 10 STEP, 11 treated as RUN (asynchronous)
step  in  1  single-step request, rising-edge triggered (asynchronous button)
clkOut  out  1  generated clock, registered
clkEn  out  1  one-cycle strobe, high in the first clkIn cycle that clkOut is high
cycleCnt  out  CNT_W  number of clkOut rising edges since reset, wraps
active  out  1  high while state != IDLE

Behaviour:
- Synchronisation:
  - divide, mode and step each pass through a SYNC_STAGES-flop chain (divS, modeS, stepS).
  - stepPrev registers stepS; stepEdge = stepS & ~stepPrev.
- Reset (rst=1 at a clkIn edge):
  - All outputs are 0 after the edge.
  - state=IDLE, cnt=0, dCur=0, synchroniser flops=0, stepPrev=0.
  - rst has priority over every other event, including mid-period; no completion of the current period.
- FSM states: IDLE, HIGH, LOW. cnt is DIV_W bits; dCur latches divS.
- IDLE:
  - clkOut=0, cnt=0.
  - Go to HIGH if modeS is RUN, or if modeS=STEP and stepEdge=1.
  - On entry to HIGH: clkOut<=1, clkEn<=1, cycleCnt<=cycleCnt+1, dCur<=divS, cnt<=0.
- HIGH:
  - clkOut=1. cnt increments each cycle.
  - When cnt==dCur: go to LOW, clkOut<=0, cnt<=0.
- LOW:
  - clkOut=0. cnt increments each cycle.
  - When cnt==dCur:
    - If modeS is RUN: go to HIGH with the same entry actions as above (dCur reloaded).
    - Otherwise: go to IDLE.
- clkEn is high for exactly one cycle per rising edge of clkOut and is 0 otherwise.
- dCur changes only at a period start, so both halves of a period use the same divisor. No runt or stretched halves.
- Mode change to STOP or STEP during a period: the period completes, then the FSM enters IDLE.
- Edge handling:
  - stepEdge is ignored outside IDLE, and ignored when modeS != STEP.
  - A held step button produces exactly one period.
- divide=0 in RUN: clkOut = clkIn/2. clkEn is high every other cycle.
- divide = all-ones: half-period of 2^DIV_W cycles. cnt never overflows.
- Latency: with SYNC_STAGES=2, clkOut rises on the 3rd clkIn edge after an input change is first sampled. This applies to step rising in STEP mode and to mode changing to RUN from IDLE.
- cycleCnt wraps from all-ones to 0.

Decomposition:
- Shared package sm_clk_pkg:
  - state enum (IDLE, HIGH, LOW).
  - mode constants MODE_STOP=2'b00, MODE_RUN=2'b01, MODE_STEP=2'b10.
- One sub-module: sm_sync (parametrised WIDTH, STAGES).
  - Synchronous active-high reset.
  - Instantiated three times: divide, mode, step.

Test Plan:
1. Reset, then mode=RUN, divide=0 → clkOut rises 3 edges after mode sampled, then toggles every cycle (period 2). clkEn pulses every 2 cycles. cycleCnt=5 after 5 rising edges.
2. RUN, divide=3 → clkOut high 4 / low 4 cycles. Change divide to 1 during a HIGH half → that period stays 4/4, the next periods are 2/2, no half of any other length.
3. mode=STEP, divide=2, step pulsed high and held 20 cycles → exactly one period (3 high, 3 low), one clkEn, cycleCnt+1, active drops to 0. A second step edge gives a second period.
4. RUN, divide=4, switch to STOP 1 cycle after clkOut rises → HIGH completes (5 cycles), LOW completes (5 cycles), clkOut stays 0 in IDLE, cycleCnt unchanged afterward.
5. rst asserted mid-HIGH in RUN → next edge clkOut=0, clkEn=0, cycleCnt=0, active=0. After rst drops with mode still RUN, clkOut restarts 3 edges later.
6. mode=11, divide=0 → identical waveform to scenario 1. step edges in RUN are ignored (waveform unchanged).

Source files
------------

// File: rtl/sm_clk_pkg.sv
// Shared FSM state encodings, mode codes and helpers for the slow-clock generator.
package sm_clk_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_HIGH = 2'd1;
    localparam state_t ST_LOW  = 2'd2;

    localparam logic [1:0] MODE_STOP = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

    // The unused encoding 2'b11 behaves exactly like RUN.
    function automatic logic is_run(input logic [1:0] m);
        return (m == MODE_RUN) || (m == 2'b11);
    endfunction

endpackage

// File: rtl/sm_sync.sv
// Multi-flop synchroniser for asynchronous board inputs; latency STAGES clk cycles.
// No flow control; every bit of the bus is sampled independently.
module sm_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/sm_clk_gen.sv
// Even-ratio 50% duty clock generator with RUN/STOP/STEP modes; clkOut rises SYNC_STAGES+1
// edges after an input change is sampled. No backpressure: clkEn is a free-running strobe.
module sm_clk_gen #(
    parameter int DIV_W       = 16,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clkIn,
    input  logic             rst,
    input  logic [DIV_W-1:0] divide,
    input  logic [1:0]       mode,
    input  logic             step,
    output logic             clkOut,
    output logic             clkEn,
    output logic [CNT_W-1:0] cycleCnt,
    output logic             active
);
    import sm_clk_pkg::*;

    logic [DIV_W-1:0] div_s;
    logic [1:0]       mode_s;
    logic             step_s;
    logic             step_prev;
    logic             step_edge;

    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] d_cur;
    logic             run;
    logic             half_done;
    logic             load;

    sm_sync #(.WIDTH(DIV_W), .STAGES(SYNC_STAGES)) u_sync_div (
        .clk (clkIn),
        .rst (rst),
        .d   (divide),
        .q   (div_s)
    );

    sm_sync #(.WIDTH(2), .STAGES(SYNC_STAGES)) u_sync_mode (
        .clk (clkIn),
        .rst (rst),
        .d   (mode),
        .q   (mode_s)
    );

    sm_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_step (
        .clk (clkIn),
        .rst (rst),
        .d   (step),
        .q   (step_s)
    );

    assign step_edge = step_s & ~step_prev;
    assign run       = is_run(mode_s);
    assign half_done = (cnt == d_cur);

    // A new period starts from IDLE on RUN or a step edge, or back-to-back from LOW in RUN.
    assign load = ((state == ST_IDLE) && (run || ((mode_s == MODE_STEP) && step_edge))) ||
                  ((state == ST_LOW) && half_done && run);

    always_ff @(posedge clkIn) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            d_cur     <= '0;
            clkOut    <= 1'b0;
            clkEn     <= 1'b0;
            cycleCnt  <= '0;
            step_prev <= 1'b0;
        end else begin
            step_prev <= step_s;
            clkEn     <= 1'b0;
            if (load) begin
                // divisor is captured only here so both halves of a period match
                state    <= ST_HIGH;
                clkOut   <= 1'b1;
                clkEn    <= 1'b1;
                cycleCnt <= cycleCnt + CNT_W'(1);
                d_cur    <= div_s;
                cnt      <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        clkOut <= 1'b0;
                        cnt    <= '0;
                    end
                    ST_HIGH: begin
                        if (half_done) begin
                            state  <= ST_LOW;
                            clkOut <= 1'b0;
                            cnt    <= '0;
                        end else begin
                            cnt <= cnt + DIV_W'(1);
                        end
                    end
                    ST_LOW: begin
                        if (half_done) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + DIV_W'(1);
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        clkOut <= 1'b0;
                        cnt    <= '0;
                    end
                endcase
            end
        end
    end

    assign active = (state != ST_IDLE);

endmodule
